// File: rtl/idex_ctrl_pipe_pkg.sv
// Shared types for the ID/EX control pipe: control-field indices,
// MemtoReg encodings and the stage FSM state enum.
package idex_ctrl_pipe_pkg;

  localparam int CTRL_W = 14;

  // ex_ctrl = {ALUSrc_B, MemtoReg[1:0], Jump[1:0], Branch, BranchN,
  //            RegWrite, MemRW, ALU_Control[3:0], ill_instr}
  localparam int CTRL_ALUSRC_B = 13;
  localparam int CTRL_MTR_HI   = 12;
  localparam int CTRL_MTR_LO   = 11;
  localparam int CTRL_JUMP_HI  = 10;
  localparam int CTRL_JUMP_LO  = 9;
  localparam int CTRL_BRANCH   = 8;
  localparam int CTRL_BRANCHN  = 7;
  localparam int CTRL_REGWRITE = 6;
  localparam int CTRL_MEMRW    = 5;
  localparam int CTRL_ALU_HI   = 4;
  localparam int CTRL_ALU_LO   = 1;
  localparam int CTRL_ILL      = 0;

  localparam logic [1:0] MTR_ALU = 2'b00;
  localparam logic [1:0] MTR_MEM = 2'b01;
  localparam logic [1:0] MTR_PC4 = 2'b10;
  localparam logic [1:0] MTR_IMM = 2'b11;

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_HOLD    = 2'd1,
    S_HOLD_FL = 2'd2
  } state_t;

endpackage

// File: rtl/idex_ctrl_pipe_hazard.sv
// Load-use comparator: EX holds a load whose rd is read by the ID instr.
// In: ex_valid, ex_mtr, ex_rd, id_rs1/2, id_rs1/2_used. Out: load_use.
module idex_hazard_detect (
  input  logic       ex_valid,
  input  logic [1:0] ex_mtr,
  input  logic [4:0] ex_rd,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_rs1_used,
  input  logic       id_rs2_used,
  output logic       load_use
);
  import idex_ctrl_pipe_pkg::*;

  logic ex_load;
  logic hit1;
  logic hit2;

  assign ex_load = ex_valid && (ex_mtr == MTR_MEM)
                && (ex_rd != 5'd0);
  assign hit1 = id_rs1_used && (id_rs1 == ex_rd);
  assign hit2 = id_rs2_used && (id_rs2 == ex_rd);
  assign load_use = ex_load && (hit1 || hit2);

endmodule

// File: rtl/idex_ctrl_pipe.sv
// ID/EX stage register with load-use bubbles, redirect squash and freeze.
// Optional perf counters under IDEX_PERF_CNT_EN (perf_bubbles,
// perf_flushes, perf_freeze_cycles). Ports: id_* in, ex_* out, stall/bubble.
module idex_ctrl_pipe #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = idex_ctrl_pipe_pkg::CTRL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              ex_redirect,
  input  logic              mio_ready,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_imm,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              stall_if_id,
  output logic              bubble_o,
`ifdef IDEX_PERF_CNT_EN
  output logic [31:0]       perf_bubbles,
  output logic [31:0]       perf_flushes,
  output logic [31:0]       perf_freeze_cycles,
`endif
  output logic              flush_pending
);
  import idex_ctrl_pipe_pkg::*;

  state_t state_q;
  state_t state_d;
  logic   fp_d;
  logic   load_use;
  logic   cap;
  logic   lu_bub;
  logic   fl_bub;

  idex_hazard_detect u_hz (
    .ex_valid    (ex_valid),
    .ex_mtr      (ex_ctrl[CTRL_MTR_HI:CTRL_MTR_LO]),
    .ex_rd       (ex_rd),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .load_use    (load_use)
  );

  always_comb begin
    state_d     = state_q;
    fp_d        = flush_pending;
    stall_if_id = 1'b0;
    cap         = 1'b0;
    lu_bub      = 1'b0;
    fl_bub      = 1'b0;
    unique case (state_q)
      S_RUN, S_HOLD: begin
        if (!mio_ready) begin
          stall_if_id = 1'b1;
          if (ex_redirect) begin
            state_d = S_HOLD_FL;
            fp_d    = 1'b1;
          end else begin
            state_d = S_HOLD;
          end
        end else begin
          state_d = S_RUN;
          if (ex_redirect) begin
            fl_bub = 1'b1;
          end else if (load_use) begin
            lu_bub      = 1'b1;
            stall_if_id = 1'b1;
          end else begin
            cap = 1'b1;
          end
        end
      end
      S_HOLD_FL: begin
        // Further redirects are absorbed: one flush only.
        stall_if_id = 1'b1;
        if (mio_ready) begin
          fl_bub      = 1'b1;
          fp_d        = 1'b0;
          stall_if_id = 1'b0;
          state_d     = S_RUN;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  assign bubble_o = fl_bub || lu_bub;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_RUN;
      flush_pending <= 1'b0;
      ex_valid      <= 1'b0;
      ex_pc         <= '0;
      ex_imm        <= '0;
      ex_rs1        <= '0;
      ex_rs2        <= '0;
      ex_rd         <= '0;
      ex_ctrl       <= '0;
    end else begin
      state_q       <= state_d;
      flush_pending <= fp_d;
      if (cap || bubble_o) begin
        ex_pc   <= id_pc;
        ex_imm  <= id_imm;
        ex_rs1  <= id_rs1;
        ex_rs2  <= id_rs2;
        ex_rd   <= id_rd;
      end
      if (bubble_o) begin
        ex_valid <= 1'b0;
        ex_ctrl  <= '0;
      end else if (cap) begin
        ex_valid <= id_valid;
        ex_ctrl  <= id_valid ? id_ctrl : '0;
      end
    end
  end

`ifdef IDEX_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_bubbles       <= '0;
      perf_flushes       <= '0;
      perf_freeze_cycles <= '0;
    end else begin
      if (lu_bub)     perf_bubbles       <= perf_bubbles + 32'd1;
      if (fl_bub)     perf_flushes       <= perf_flushes + 32'd1;
      if (!mio_ready) perf_freeze_cycles <= perf_freeze_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_idex_ctrl_pipe.sv
// Directed bench for idex_ctrl_pipe: flow, load-use, redirect,
// freeze with flush and reset mid-freeze.
module tb_idex_ctrl_pipe;

  localparam int XLEN = 32;
  localparam int CW   = 14;
  localparam logic [CW-1:0] C_ADDI = 14'h2040;
  localparam logic [CW-1:0] C_LW   = 14'h2840;
  localparam logic [CW-1:0] C_ADD  = 14'h0040;
  localparam logic [CW-1:0] C_LUI  = 14'h1840;

  logic            clk = 1'b0;
  logic            rst;
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_imm;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic [4:0]      id_rd;
  logic            id_rs1_used;
  logic            id_rs2_used;
  logic [CW-1:0]   id_ctrl;
  logic            ex_redirect;
  logic            mio_ready;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_imm;
  logic [4:0]      ex_rs1;
  logic [4:0]      ex_rs2;
  logic [4:0]      ex_rd;
  logic [CW-1:0]   ex_ctrl;
  logic            stall_if_id;
  logic            bubble_o;
  logic            flush_pending;
`ifdef IDEX_PERF_CNT_EN
  logic [31:0]     perf_bubbles;
  logic [31:0]     perf_flushes;
  logic [31:0]     perf_freeze_cycles;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  idex_ctrl_pipe #(.XLEN(XLEN), .CTRL_W(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .id_valid      (id_valid),
    .id_pc         (id_pc),
    .id_imm        (id_imm),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_rd         (id_rd),
    .id_rs1_used   (id_rs1_used),
    .id_rs2_used   (id_rs2_used),
    .id_ctrl       (id_ctrl),
    .ex_redirect   (ex_redirect),
    .mio_ready     (mio_ready),
    .ex_valid      (ex_valid),
    .ex_pc         (ex_pc),
    .ex_imm        (ex_imm),
    .ex_rs1        (ex_rs1),
    .ex_rs2        (ex_rs2),
    .ex_rd         (ex_rd),
    .ex_ctrl       (ex_ctrl),
    .stall_if_id   (stall_if_id),
    .bubble_o      (bubble_o),
`ifdef IDEX_PERF_CNT_EN
    .perf_bubbles       (perf_bubbles),
    .perf_flushes       (perf_flushes),
    .perf_freeze_cycles (perf_freeze_cycles),
`endif
    .flush_pending (flush_pending)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic u1,
                       input logic u2, input logic [CW-1:0] c);
    id_valid    = v;
    id_pc       = pc;
    id_imm      = pc + 32'h10;
    id_rs1      = rs1;
    id_rs2      = rs2;
    id_rd       = rd;
    id_rs1_used = u1;
    id_rs2_used = u2;
    id_ctrl     = c;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ex_redirect = 1'b0; mio_ready = 1'b1;
    drive(1'b1, 32'h50, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, C_ADD);
    step(); step();
    total++;
    if (ex_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", ex_valid);
    else passed++;
    total++;
    if (ex_ctrl !== '0) $display("FAIL rst_ctrl got %h want 0", ex_ctrl);
    else passed++;
    total++;
    if (ex_pc !== '0 || ex_rd !== '0)
      $display("FAIL rst_pc_rd got %h/%0d want 0/0", ex_pc, ex_rd);
    else passed++;
    total++;
    if (flush_pending !== 1'b0)
      $display("FAIL rst_fp got %b want 0", flush_pending);
    else passed++;
`ifdef IDEX_PERF_CNT_EN
    total++;
    if (perf_bubbles !== 0 || perf_flushes !== 0 || perf_freeze_cycles !== 0)
      $display("FAIL rst_perf got %0d/%0d/%0d want 0/0/0",
               perf_bubbles, perf_flushes, perf_freeze_cycles);
    else passed++;
`endif
    rst = 1'b0;
  endtask

  task automatic test_normal();
    drive(1'b1, 32'h100, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, C_ADDI);
    total++;
    if (stall_if_id !== 1'b0 || bubble_o !== 1'b0)
      $display("FAIL norm_c1 got %b%b want 00", stall_if_id, bubble_o);
    else passed++;
    step();
    total++;
    if (ex_valid !== 1'b1 || ex_pc !== 32'h100 || ex_rd !== 5'd5 ||
        ex_ctrl !== C_ADDI)
      $display("FAIL norm_ex1 got %b %h %0d %h want 1 100 5 %h",
               ex_valid, ex_pc, ex_rd, ex_ctrl, C_ADDI);
    else passed++;
    drive(1'b1, 32'h104, 5'd5, 5'd5, 5'd6, 1'b1, 1'b1, C_ADD);
    total++;
    if (stall_if_id !== 1'b0 || bubble_o !== 1'b0)
      $display("FAIL norm_c2 got %b%b want 00", stall_if_id, bubble_o);
    else passed++;
    step();
    total++;
    if (ex_valid !== 1'b1 || ex_pc !== 32'h104 || ex_rd !== 5'd6 ||
        ex_ctrl !== C_ADD || ex_imm !== 32'h114 || ex_rs1 !== 5'd5)
      $display("FAIL norm_ex2 got %b %h %0d %h want 1 104 6 %h",
               ex_valid, ex_pc, ex_rd, ex_ctrl, C_ADD);
    else passed++;
  endtask

  task automatic test_load_use();
    drive(1'b1, 32'h200, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, C_LW);
    step();
    drive(1'b1, 32'h204, 5'd5, 5'd2, 5'd7, 1'b1, 1'b1, C_ADD);
    total++;
    if (stall_if_id !== 1'b1 || bubble_o !== 1'b1)
      $display("FAIL lu_detect got %b%b want 11", stall_if_id, bubble_o);
    else passed++;
    step();
    total++;
    if (ex_valid !== 1'b0 || ex_ctrl !== '0)
      $display("FAIL lu_bubble got %b %h want 0 0", ex_valid, ex_ctrl);
    else passed++;
    total++;
    if (stall_if_id !== 1'b0 || bubble_o !== 1'b0)
      $display("FAIL lu_once got %b%b want 00", stall_if_id, bubble_o);
    else passed++;
    step();
    total++;
    if (ex_valid !== 1'b1 || ex_pc !== 32'h204 || ex_ctrl !== C_ADD)
      $display("FAIL lu_enter got %b %h %h want 1 204 %h",
               ex_valid, ex_pc, ex_ctrl, C_ADD);
    else passed++;
  endtask

  task automatic test_unused_x0();
    drive(1'b1, 32'h300, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, C_LW);
    step();
    drive(1'b1, 32'h304, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, C_LUI);
    total++;
    if (stall_if_id !== 1'b0 || bubble_o !== 1'b0)
      $display("FAIL unused got %b%b want 00", stall_if_id, bubble_o);
    else passed++;
    drive(1'b1, 32'h304, 5'd3, 5'd5, 5'd8, 1'b1, 1'b1, C_ADD);
    total++;
    if (stall_if_id !== 1'b1 || bubble_o !== 1'b1)
      $display("FAIL rs2_hit got %b%b want 11", stall_if_id, bubble_o);
    else passed++;
    drive(1'b1, 32'h304, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, C_LUI);
    step();
    total++;
    if (ex_valid !== 1'b1 || ex_ctrl !== C_LUI)
      $display("FAIL lui_ex got %b %h want 1 %h", ex_valid, ex_ctrl, C_LUI);
    else passed++;
    drive(1'b1, 32'h308, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, C_LW);
    step();
    drive(1'b1, 32'h30c, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1, C_ADD);
    total++;
    if (stall_if_id !== 1'b0 || bubble_o !== 1'b0)
      $display("FAIL x0 got %b%b want 00", stall_if_id, bubble_o);
    else passed++;
    step();
  endtask

  task automatic test_redirect();
    drive(1'b1, 32'h350, 5'd1, 5'd2, 5'd4, 1'b1, 1'b1, C_ADD);
    ex_redirect = 1'b1;
    #1;
    total++;
    if (bubble_o !== 1'b1 || stall_if_id !== 1'b0)
      $display("FAIL redir_c got %b%b want 10", bubble_o, stall_if_id);
    else passed++;
    step();
    ex_redirect = 1'b0;
    total++;
    if (ex_valid !== 1'b0 || ex_ctrl !== '0)
      $display("FAIL redir_ex got %b %h want 0 0", ex_valid, ex_ctrl);
    else passed++;
  endtask

  task automatic test_freeze_flush();
    drive(1'b1, 32'h400, 5'd1, 5'd0, 5'd9, 1'b1, 1'b0, C_ADDI);
    step();
    drive(1'b1, 32'h404, 5'd1, 5'd2, 5'd10, 1'b1, 1'b1, C_ADD);
    mio_ready = 1'b0;
    #1;
    total++;
    if (stall_if_id !== 1'b1 || bubble_o !== 1'b0)
      $display("FAIL frz_c1 got %b%b want 10", stall_if_id, bubble_o);
    else passed++;
    step();
    ex_redirect = 1'b1;
    #1;
    total++;
    if (stall_if_id !== 1'b1 || flush_pending !== 1'b0)
      $display("FAIL frz_c2 got %b%b want 10", stall_if_id, flush_pending);
    else passed++;
    step();
    ex_redirect = 1'b0;
    total++;
    if (flush_pending !== 1'b1 || ex_valid !== 1'b1 || ex_pc !== 32'h400)
      $display("FAIL frz_c3 got %b %b %h want 1 1 400",
               flush_pending, ex_valid, ex_pc);
    else passed++;
    step();
    mio_ready = 1'b1;
    #1;
    total++;
    if (bubble_o !== 1'b1 || ex_ctrl !== C_ADDI)
      $display("FAIL frz_rel got %b %h want 1 %h", bubble_o, ex_ctrl, C_ADDI);
    else passed++;
    step();
    total++;
    if (ex_valid !== 1'b0 || ex_ctrl !== '0 || flush_pending !== 1'b0)
      $display("FAIL frz_bub got %b %h %b want 0 0 0",
               ex_valid, ex_ctrl, flush_pending);
    else passed++;
    step();
    total++;
    if (ex_valid !== 1'b1 || ex_pc !== 32'h404)
      $display("FAIL frz_next got %b %h want 1 404", ex_valid, ex_pc);
    else passed++;
  endtask

  task automatic test_reset_mid_freeze();
    mio_ready   = 1'b0;
    ex_redirect = 1'b1;
    step();
    step();
    ex_redirect = 1'b0;
    total++;
    if (flush_pending !== 1'b1)
      $display("FAIL rmf_fp got %b want 1", flush_pending);
    else passed++;
    rst = 1'b1;
    step();
    total++;
    if (ex_valid !== 1'b0 || flush_pending !== 1'b0 || ex_ctrl !== '0)
      $display("FAIL rmf_rst got %b %b %h want 0 0 0",
               ex_valid, flush_pending, ex_ctrl);
    else passed++;
`ifdef IDEX_PERF_CNT_EN
    total++;
    if (perf_bubbles !== 0 || perf_flushes !== 0 || perf_freeze_cycles !== 0)
      $display("FAIL rmf_perf got %0d/%0d/%0d want 0/0/0",
               perf_bubbles, perf_flushes, perf_freeze_cycles);
    else passed++;
`endif
    rst = 1'b0;
    mio_ready = 1'b1;
    drive(1'b1, 32'h500, 5'd1, 5'd2, 5'd11, 1'b1, 1'b1, C_ADD);
    total++;
    if (bubble_o !== 1'b0 || stall_if_id !== 1'b0)
      $display("FAIL rmf_lost got %b%b want 00", bubble_o, stall_if_id);
    else passed++;
    step();
    total++;
    if (ex_valid !== 1'b1 || ex_pc !== 32'h500)
      $display("FAIL rmf_run got %b %h want 1 500", ex_valid, ex_pc);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_normal();
    test_load_use();
    test_unused_x0();
    test_redirect();
    test_freeze_flush();
    test_reset_mid_freeze();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/idex_ctrl_pipe.md
Name: idex_ctrl_pipe

Overview:
- ID/EX boundary stage: registers the decoded control bundle, operand indices, PC and immediate from the decode stage into EX.
- Detects load-use hazards using the Rs1_used/Rs2_used qualifiers and inserts bubbles.
- Squashes the ID slot on an EX redirect.
- Freezes the whole stage while memory is not ready.

Parameters:
- XLEN, 32, width of PC and immediate.
- CTRL_W, 14, packed control width: {ALUSrc_B, MemtoReg[1:0], Jump[1:0], Branch, BranchN, RegWrite, MemRW, ALU_Control[3:0], ill_instr}.

Ports:
- clk  in  1  stage clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID slot holds a real instruction.
- id_pc  in  XLEN  PC of ID instruction.
- id_imm  in  XLEN  generated immediate.
- id_rs1, id_rs2, id_rd  in  5 each  register indices.
- id_rs1_used, id_rs2_used  in  1 each  source-operand-used qualifiers.
- id_ctrl  in  CTRL_W  packed decode outputs.
- ex_redirect  in  1  branch/jump taken in EX; the ID slot is wrong-path.
- mio_ready  in  1  memory ready; 0 freezes the stage.
- ex_valid  out  1  EX slot valid.
- ex_pc, ex_imm  out  XLEN  registered copies.
- ex_rs1, ex_rs2, ex_rd  out  5 each  registered indices.
- ex_ctrl  out  CTRL_W  registered control; all-zero when bubble.
- stall_if_id  out  1  hold PC and IF/ID this cycle (combinational).
- bubble_o  out  1  a bubble is being inserted this cycle (combinational).
- flush_pending  out  1  a redirect has been captured during a freeze.

Behaviour:
- Reset: all ex_* = 0, ex_ctrl = 0 (RegWrite = 0, MemRW = 0, so a NOP), ex_valid = 0, flush_pending = 0, FSM = S_RUN.
- Latency: 1 cycle ID to EX when no stall.
- Bubble: writes ex_valid = 0 and ex_ctrl = 0. ex_pc, ex_rd and ex_imm take the ID values (don't-care for a bubble), and the bench must not check them.
- Load-use condition (combinational):
  - ex_valid && ex_ctrl MemtoReg == 2'b01 && ex_rd != 0
  - && ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd)).
- Unused sources never cause a stall (lui, jal, and rs2 of I-type are ignored). A match with rd = x0 never stalls.
- FSM states: S_RUN, S_HOLD, S_HOLD_FL.
- Priority, highest first: rst > !mio_ready > flush (ex_redirect or flush_pending) > load-use > normal.
- S_RUN, mio_ready = 0:
  - All EX registers hold; stall_if_id = 1.
  - If ex_redirect, go to S_HOLD_FL and set flush_pending = 1; otherwise go to S_HOLD.
- S_RUN, mio_ready = 1:
  - If ex_redirect: bubble, stall_if_id = 0.
  - Else if load-use: bubble, stall_if_id = 1 (exactly one bubble per load-use pair).
  - Else: capture ID (ex_valid = id_valid).
- S_HOLD:
  - Registers hold; stall_if_id = 1.
  - ex_redirect moves to S_HOLD_FL.
  - mio_ready = 1 with no redirect returns to S_RUN; the same-cycle action is evaluated as in S_RUN.
- S_HOLD_FL:
  - Registers hold; stall_if_id = 1.
  - On mio_ready = 1: bubble, clear flush_pending, go to S_RUN.
- A load-use condition that coincides with a flush is discarded, because the ID instruction is squashed.
- ex_redirect while id_valid = 0 still inserts a bubble; this is harmless.
- A second redirect while flush_pending is already set is absorbed, so only one flush is applied.
- rst asserted mid-freeze or mid-stall returns everything to reset values on the next edge; the pending flush is lost.

Optional Feature:
- IDEX_PERF_CNT_EN.
- Defined: adds three 32-bit wrapping outputs, perf_bubbles, perf_flushes and perf_freeze_cycles.
  - Each increments on a cycle where load-use bubble, flush bubble or mio_ready = 0 respectively.
  - All reset to 0.
- Undefined: these ports and registers are absent; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - CTRL_W and the bit-field index constants for ex_ctrl.
  - MemtoReg encodings: MTR_ALU = 00, MTR_MEM = 01, MTR_PC4 = 10, MTR_IMM = 11.
  - FSM state enum.
- One natural sub-module: idex_hazard_detect, a purely combinational load-use comparator producing a load_use flag.

Test Plan:
- Normal flow: addi x5 then add x6,x5,x5, mio_ready = 1 -> second instruction reaches EX one cycle later; no bubble; stall_if_id = 0 throughout.
- Load-use: lw x5 in EX (MemtoReg = 01, rd = 5), ID add rs1 = 5 used -> bubble_o = 1, stall_if_id = 1 for exactly 1 cycle; add enters EX the next cycle.
- Unused operand or x0: EX lw rd = 5 with ID lui rd = 5 (rs*_used = 0) -> no stall. EX lw rd = 0 with ID rs1 = 0 -> no stall.
- Redirect: ex_redirect = 1 with valid ID -> next cycle ex_valid = 0, ex_ctrl = 0.
- Freeze with flush: mio_ready = 0 for 3 cycles, with ex_redirect pulsed on the 2nd -> EX holds, flush_pending = 1 from the 3rd cycle. When mio_ready returns to 1, one bubble, flush_pending = 0.
- Reset mid-freeze: rst = 1 in S_HOLD_FL -> next edge: ex_valid = 0, flush_pending = 0, FSM = S_RUN. With IDEX_PERF_CNT_EN, counters read 0.
